// File: rtl/hist_pkg.sv
// Shared types and helpers for the histogram sequencer.
// Optional build macro HIST_SAT_EN selects saturating bin counts (see hist_rmw_stage).
package hist_pkg;

    // Default configuration values used as module parameter defaults.
    localparam int DEF_SIZE        = 7;
    localparam int DEF_MAX_NUMBER  = 127;
    localparam int DEF_NUM_SAMPLES = 1024;

    // Sequencer states; exported on the debug port of the top.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        ACCUM = 3'd2,
        DUMP  = 3'd3,
        DONE  = 3'd4
    } state_e;

    // Bin count at the default counter width.
    typedef logic [DEF_SIZE-1:0] count_t;

    // Address width needed to reach bins 0..max_number.
    function automatic int addr_w(input int max_number);
        if (max_number < 1) return 1;
        return $clog2(max_number + 1);
    endfunction

endpackage

// File: rtl/hist_rmw_stage.sv
// Read-modify-write pipeline for bin accumulation.
// Stage 1 is the accept cycle (the read address is driven by the top); stage 2
// writes count+1 back. Because the RAM is read-first, a sample whose read
// overlapped the previous cycle's write to the same bin sees stale data, so the
// last written value is forwarded instead.
// HIST_SAT_EN defined: counts hold at all-ones and ovf_o pulses; otherwise counts wrap.
module hist_rmw_stage
    import hist_pkg::*;
#(
    parameter int SIZE   = DEF_SIZE,
    parameter int ADDR_W = 7
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              acc_i,
    input  logic [ADDR_W-1:0] bin_i,
    input  logic [SIZE-1:0]   rdata_i,
    output logic              we_o,
    output logic [ADDR_W-1:0] waddr_o,
    output logic [SIZE-1:0]   wdata_o,
    output logic              ovf_o
);

    logic              s2_valid_q;
    logic [ADDR_W-1:0] s2_bin_q;
    logic              w_valid_q;
    logic [ADDR_W-1:0] w_bin_q;
    logic [SIZE-1:0]   w_data_q;
    logic [SIZE-1:0]   cnt;
    logic [SIZE-1:0]   wdata_d;
    logic              ovf_d;

    // Pipeline registers: stage 2 request and a copy of the last committed write.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s2_valid_q <= 1'b0;
            s2_bin_q   <= '0;
            w_valid_q  <= 1'b0;
            w_bin_q    <= '0;
            w_data_q   <= '0;
        end else begin
            s2_valid_q <= acc_i;
            s2_bin_q   <= bin_i;
            w_valid_q  <= s2_valid_q;
            w_bin_q    <= s2_bin_q;
            w_data_q   <= wdata_d;
        end
    end

    // Select forwarded or RAM count, then increment (wrap or saturate).
    always_comb begin
        cnt     = (w_valid_q && (w_bin_q == s2_bin_q)) ? w_data_q : rdata_i;
        wdata_d = cnt + 1'b1;
        ovf_d   = 1'b0;
`ifdef HIST_SAT_EN
        if (cnt == {SIZE{1'b1}}) begin
            wdata_d = cnt;
            ovf_d   = s2_valid_q;
        end
`endif
    end

    assign we_o    = s2_valid_q;
    assign waddr_o = s2_bin_q;
    assign wdata_o = wdata_d;
    assign ovf_o   = ovf_d;

endmodule

// File: rtl/histogram_sequencer.sv
// Histogram engine controller: clears every bin, accumulates NUM_SAMPLES samples
// by read-modify-write into an external simple-dual-port RAM, then streams all
// bin counts out. Build macro HIST_SAT_EN enables saturating counts and ovf.
// Handshake: a sample transfers on a rising clock edge where s_valid && s_ready;
// s_ready does not depend on s_valid, and s_data must be stable while s_valid is high.
module histogram_sequencer
    import hist_pkg::*;
#(
    parameter int  SIZE        = DEF_SIZE,
    parameter int  MAX_NUMBER  = DEF_MAX_NUMBER,
    parameter int  NUM_SAMPLES = DEF_NUM_SAMPLES,
    localparam int ADDR_W      = addr_w(MAX_NUMBER)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic              s_valid,
    input  logic [ADDR_W-1:0] s_data,
    output logic              s_ready,
    output logic [ADDR_W-1:0] mem_raddr,
    input  logic [SIZE-1:0]   mem_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [SIZE-1:0]   mem_wdata,
    output logic              rd_valid,
    output logic [ADDR_W-1:0] rd_bin,
    output logic [SIZE-1:0]   rd_count,
    output logic              busy,
    output logic              done,
    output logic              ovf,
    output state_e            dbg_state_o
);

    localparam int                SCNT_W      = $clog2(NUM_SAMPLES + 1);
    localparam logic [ADDR_W-1:0] LAST_BIN    = ADDR_W'(MAX_NUMBER);
    localparam logic [SCNT_W-1:0] LAST_SAMPLE = SCNT_W'(NUM_SAMPLES);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] bin_q, bin_d;
    logic [SCNT_W-1:0] accepted_q, accepted_d;
    logic              dump_last_q, dump_last_d;
    logic              rd_valid_q, rd_valid_d;
    logic [ADDR_W-1:0] rd_bin_q;
    logic              ovf_q, ovf_d;
    logic              accept;
    logic              in_range;
    logic              rmw_we;
    logic [ADDR_W-1:0] rmw_waddr;
    logic [SIZE-1:0]   rmw_wdata;
    logic              rmw_ovf;

    assign s_ready = (state_q == ACCUM) && (accepted_q != LAST_SAMPLE);
    assign accept  = s_valid && s_ready;

    // Out-of-range samples still count toward NUM_SAMPLES but never touch the RAM.
    generate
        if (MAX_NUMBER >= (1 << ADDR_W) - 1) begin : g_full_range
            assign in_range = 1'b1;
        end else begin : g_part_range
            assign in_range = (s_data <= LAST_BIN);
        end
    endgenerate

    hist_rmw_stage #(
        .SIZE   (SIZE),
        .ADDR_W (ADDR_W)
    ) u_rmw (
        .clk_i   (CLK),
        .rst_i   (RST),
        .acc_i   (accept && in_range),
        .bin_i   (s_data),
        .rdata_i (mem_rdata),
        .we_o    (rmw_we),
        .waddr_o (rmw_waddr),
        .wdata_o (rmw_wdata),
        .ovf_o   (rmw_ovf)
    );

    // Next-state logic: sequencing, bin walk, sample count, sticky overflow.
    always_comb begin
        state_d     = state_q;
        bin_d       = bin_q;
        accepted_d  = accepted_q;
        dump_last_d = 1'b0;
        rd_valid_d  = 1'b0;
        ovf_d       = ovf_q;
        unique case (state_q)
            IDLE: begin
                bin_d      = '0;
                accepted_d = '0;
                if (start) begin
                    state_d = CLEAR;
                    ovf_d   = 1'b0;
                end
            end
            CLEAR: begin
                if (bin_q == LAST_BIN) begin
                    bin_d   = '0;
                    state_d = ACCUM;
                end else begin
                    bin_d = bin_q + 1'b1;
                end
            end
            ACCUM: begin
                if (accept) accepted_d = accepted_q + 1'b1;
                // Count full means this is the drain cycle: last write commits now.
                if (accepted_q == LAST_SAMPLE) state_d = DUMP;
            end
            DUMP: begin
                // One extra cycle after the last read lets its data reach rd_count.
                rd_valid_d  = !dump_last_q;
                dump_last_d = (bin_q == LAST_BIN);
                if (bin_q != LAST_BIN) bin_d = bin_q + 1'b1;
                if (dump_last_q) state_d = DONE;
            end
            DONE: begin
                bin_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // In the wrapping build rmw_ovf is constant 0, so ovf never sets.
        if (rmw_ovf) ovf_d = 1'b1;
    end

    // State and datapath registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            bin_q       <= '0;
            accepted_q  <= '0;
            dump_last_q <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_bin_q    <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            bin_q       <= bin_d;
            accepted_q  <= accepted_d;
            dump_last_q <= dump_last_d;
            rd_valid_q  <= rd_valid_d;
            if (rd_valid_d) rd_bin_q <= bin_q;
            ovf_q       <= ovf_d;
        end
    end

    assign mem_raddr   = (state_q == ACCUM) ? s_data : bin_q;
    assign mem_we      = (state_q == CLEAR) || rmw_we;
    assign mem_waddr   = rmw_we ? rmw_waddr : bin_q;
    assign mem_wdata   = rmw_we ? rmw_wdata : '0;
    assign rd_valid    = rd_valid_q;
    assign rd_bin      = rd_bin_q;
    assign rd_count    = rd_valid_q ? mem_rdata : '0;
    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign ovf         = ovf_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_histogram_sequencer.sv
// Bench for histogram_sequencer with a behavioural RAM and a histogram model.
module tb_histogram_sequencer;
    import hist_pkg::*;

    localparam int SIZE = 7;
    localparam int MAXN = 127;
    localparam int NS   = 1024;
    localparam int AW   = 7;
    localparam int NB   = MAXN + 1;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic            s_valid = 1'b0;
    logic [AW-1:0]   s_data = '0;
    logic            s_ready;
    logic [AW-1:0]   mem_raddr;
    logic [SIZE-1:0] mem_rdata;
    logic            mem_we;
    logic [AW-1:0]   mem_waddr;
    logic [SIZE-1:0] mem_wdata;
    logic            rd_valid;
    logic [AW-1:0]   rd_bin;
    logic [SIZE-1:0] rd_count;
    logic            busy;
    logic            done;
    logic            ovf;
    state_e          dbg_state;

    int tests_run = 0;
    int tests_failed = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- bin RAM: sync read, read-first ----------------
    logic [SIZE-1:0] ram [NB];
    always @(posedge clk) begin
        if (mem_we) ram[mem_waddr] <= mem_wdata;
        mem_rdata <= ram[mem_raddr];
    end

    histogram_sequencer #(
        .SIZE        (SIZE),
        .MAX_NUMBER  (MAXN),
        .NUM_SAMPLES (NS)
    ) dut (
        .CLK         (clk),
        .RST         (rst),
        .start       (start),
        .s_valid     (s_valid),
        .s_data      (s_data),
        .s_ready     (s_ready),
        .mem_raddr   (mem_raddr),
        .mem_rdata   (mem_rdata),
        .mem_we      (mem_we),
        .mem_waddr   (mem_waddr),
        .mem_wdata   (mem_wdata),
        .rd_valid    (rd_valid),
        .rd_bin      (rd_bin),
        .rd_count    (rd_count),
        .busy        (busy),
        .done        (done),
        .ovf         (ovf),
        .dbg_state_o (dbg_state)
    );

    // ---------------- output monitor ----------------
    logic [AW-1:0]   got_bin_q[$];
    logic [SIZE-1:0] got_cnt_q[$];
    logic [SIZE-1:0] exp_q[$];
    int done_cnt, done_cyc, last_rd_cyc;
    bit done_prev, busy_at_done, busy_after_done;

    always @(negedge clk) begin
        if (rd_valid) begin
            got_bin_q.push_back(rd_bin);
            got_cnt_q.push_back(rd_count);
            last_rd_cyc = cyc;
        end
        if (done_prev) busy_after_done = busy;
        done_prev = done;
        if (done) begin
            done_cnt++;
            done_cyc     = cyc;
            busy_at_done = busy;
        end
    end

    task automatic clear_monitor();
        got_bin_q.delete();
        got_cnt_q.delete();
        exp_q.delete();
        done_cnt        = 0;
        done_cyc        = -1;
        last_rd_cyc     = -10;
        done_prev       = 1'b0;
        busy_at_done    = 1'b0;
        busy_after_done = 1'b1;
    endtask

    // ---------------- stimulus + reference model ----------------
    // mode: 0 stride-11, 1 all fives, 2 random 0..127, 3 random 0..15, 4 random 0..3
    task automatic gen_samples(input int mode, output logic [AW-1:0] smp[$]);
        int prev;
        prev = 0;
        smp.delete();
        for (int i = 0; i < NS; i++) begin
            case (mode)
                0: begin smp.push_back(AW'(prev)); prev = (prev + 11) % NB; end
                1: smp.push_back(AW'(5));
                2: smp.push_back(AW'($urandom_range(0, MAXN)));
                3: smp.push_back(AW'($urandom_range(0, 15)));
                default: smp.push_back(AW'($urandom_range(0, 3)));
            endcase
        end
    endtask

    // Histogram of a sample list under the selected counting rule.
    task automatic model_hist(input logic [AW-1:0] smp[$], output int m[NB], output bit eovf);
        foreach (m[i]) m[i] = 0;
        eovf = 1'b0;
        foreach (smp[i]) begin
`ifdef HIST_SAT_EN
            if (m[smp[i]] == (1 << SIZE) - 1) eovf = 1'b1;
            else m[smp[i]] = m[smp[i]] + 1;
`else
            m[smp[i]] = (m[smp[i]] + 1) % (1 << SIZE);
`endif
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Full run: start, feed samples (optionally with gaps), collect the dump, check it.
    task automatic run_case(input string name, input int mode, input bit gaps, input bit start_in_dump);
        logic [AW-1:0] smp[$];
        int  m[NB];
        bit  eovf;
        int  idx, guard;
        bit  pulsed;
        logic [AW-1:0]   b;
        logic [SIZE-1:0] c, e;

        gen_samples(mode, smp);
        model_hist(smp, m, eovf);
        clear_monitor();
        for (int i = 0; i < NB; i++) exp_q.push_back(SIZE'(m[i]));

        pulse_start();
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s busy_after_start got=%0b want=1", name, busy);
        end

        idx = 0;
        guard = 0;
        while (idx < NS && guard < 4 * NS) begin
            s_valid = gaps ? 1'(guard % 2) : 1'b1;
            s_data  = smp[idx];
            if (s_valid && s_ready) idx++;
            @(posedge clk); #1;
            guard++;
        end
        s_valid = 1'b0;
        tests_run++;
        if (idx != NS) begin
            tests_failed++;
            $display("FAIL %s samples_accepted got=%0d want=%0d", name, idx, NS);
        end
        tests_run++;
        if (s_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s s_ready_after_last got=%0b want=0", name, s_ready);
        end

        guard = 0;
        pulsed = 1'b0;
        while (done_cnt == 0 && guard < 1000) begin
            if (start_in_dump && !pulsed && got_bin_q.size() >= 10) begin
                start = 1'b1;
                pulsed = 1'b1;
            end
            @(posedge clk); #1;
            start = 1'b0;
            guard++;
        end
        repeat (6) begin @(posedge clk); #1; end

        tests_run++;
        if (done_cnt == 0) begin
            tests_failed++;
            $display("FAIL %s done_timeout got=none want=pulse", name);
        end
        tests_run++;
        if (got_bin_q.size() != NB) begin
            tests_failed++;
            $display("FAIL %s rd_valid_count got=%0d want=%0d", name, got_bin_q.size(), NB);
        end
        for (int i = 0; i < NB && got_bin_q.size() > 0; i++) begin
            b = got_bin_q.pop_front();
            c = got_cnt_q.pop_front();
            e = exp_q.pop_front();
            tests_run++;
            if (b !== AW'(i) || c !== e) begin
                tests_failed++;
                $display("FAIL %s dump[%0d] got bin=%0d count=%0d want bin=%0d count=%0d",
                         name, i, b, c, i, e);
            end
        end
        tests_run++;
        if (done_cnt != 1) begin
            tests_failed++;
            $display("FAIL %s done_pulses got=%0d want=1", name, done_cnt);
        end
        tests_run++;
        if (done_cyc != last_rd_cyc + 1) begin
            tests_failed++;
            $display("FAIL %s done_timing got=cycle %0d want=cycle %0d", name, done_cyc, last_rd_cyc + 1);
        end
        tests_run++;
        if (busy_at_done !== 1'b1 || busy_after_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s busy_around_done got=%0b/%0b want=1/0", name, busy_at_done, busy_after_done);
        end
        tests_run++;
        if (ovf !== eovf) begin
            tests_failed++;
            $display("FAIL %s ovf got=%0b want=%0b", name, ovf, eovf);
        end
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s busy_idle_at_end got=%0b want=0", name, busy);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if ({busy, done, s_ready, mem_we, rd_valid, ovf} !== 6'b0 ||
            mem_raddr !== '0 || mem_waddr !== '0 || mem_wdata !== '0 ||
            rd_bin !== '0 || rd_count !== '0) begin
            tests_failed++;
            $display("FAIL reset_state got busy=%0b done=%0b rdy=%0b we=%0b rv=%0b ovf=%0b ra=%0d wa=%0d wd=%0d want all 0",
                     busy, done, s_ready, mem_we, rd_valid, ovf, mem_raddr, mem_waddr, mem_wdata);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_after_reset busy got=%0b want=0", busy);
        end
    endtask

    task automatic test_reset_mid_accum();
        logic [AW-1:0] smp[$];
        int  m[NB];
        bit  eovf;
        int  idx, guard;
        // Enough identical samples to pass the counter maximum before reset.
        smp.delete();
        for (int i = 0; i < 300; i++) smp.push_back(AW'(5));
        model_hist(smp, m, eovf);
        pulse_start();
        idx = 0;
        guard = 0;
        while (idx < 300 && guard < 1000) begin
            s_valid = 1'b1;
            s_data  = smp[idx];
            if (s_ready) idx++;
            @(posedge clk); #1;
            guard++;
        end
        @(posedge clk); #1;
        tests_run++;
        if (ovf !== eovf || s_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_accum_before_rst got ovf=%0b rdy=%0b want ovf=%0b rdy=1", ovf, s_ready, eovf);
        end
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if ({busy, s_ready, mem_we, ovf} !== 4'b0) begin
            tests_failed++;
            $display("FAIL async_reset got busy=%0b rdy=%0b we=%0b ovf=%0b want 0000", busy, s_ready, mem_we, ovf);
        end
        s_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run_case("after_reset", 2, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        run_case("stride", 0, 1'b0, 1'b0);
        run_case("saturate", 1, 1'b0, 1'b0);
        run_case("random_full", 2, 1'b0, 1'b0);
        run_case("clear_second_run", 3, 1'b0, 1'b0);
        run_case("gaps", 0, 1'b1, 1'b0);
        run_case("back_to_back", 4, 1'b0, 1'b0);
        test_reset_mid_accum();
        run_case("start_in_dump", 2, 1'b0, 1'b1);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
